// File: rtl/fft_out_buf.sv
// fft_out_buf: output-side reorder buffer for the 64-point FFT datapath.
// The 8-point core writes one group (8 complex points) per strobe. Lane j of
// group g lands at frequency index k = j*SIZE_GRP + g. The buffer then streams
// one sample per cycle in frequency order under a valid/ready handshake.
// Two banks ping-pong, so the next frame fills while the current one drains.
// Build option: define FFT_OUT_BITREV_EN to emit samples in bit-reversed order
// (read address = idx_o = bitrev(count)). The default build emits natural order.
module fft_out_buf #(
    parameter int DAT_WD   = 16,
    parameter int SIZE_FFT = 64,
    parameter int SIZE_GRP = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          grp_val_i,
    input  logic [$clog2(SIZE_GRP)-1:0]   grp_idx_i,
    input  logic [SIZE_GRP*2*DAT_WD-1:0]  grp_dat_i,
    output logic                          grp_rdy_o,
    output logic                          val_o,
    input  logic                          rdy_i,
    output logic signed [DAT_WD-1:0]      fft_dat_re_o,
    output logic signed [DAT_WD-1:0]      fft_dat_im_o,
    output logic [$clog2(SIZE_FFT)-1:0]   idx_o,
    output logic                          last_o
);

    localparam int ADDR_W = $clog2(SIZE_FFT);
    localparam int WORD_W = 2 * DAT_WD;
    localparam int MEM_D  = 2 * SIZE_FFT;
    localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(SIZE_FFT - 1);

    typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_DRAINING} bank_st_t;
    typedef enum logic {RD_IDLE, RD_STREAM} rd_st_t;

    // Both banks share one array; the bank number is the top address bit.
    logic [WORD_W-1:0]        mem_q [MEM_D];

    bank_st_t                 bank_st_q [2];
    bank_st_t                 bank_st_d [2];
    logic [SIZE_GRP-1:0]      mask_q [2];
    logic [SIZE_GRP-1:0]      mask_d [2];
    logic                     wr_ptr_q, wr_ptr_d;
    logic                     rd_ptr_q, rd_ptr_d;

    rd_st_t                   rd_st_q, rd_st_d;
    logic [ADDR_W-1:0]        cnt_q, cnt_d;
    logic                     val_q, val_d;
    logic                     last_q, last_d;
    logic [ADDR_W-1:0]        idx_q, idx_d;
    logic signed [DAT_WD-1:0] re_q, re_d;
    logic signed [DAT_WD-1:0] im_q, im_d;

    logic                     wr_en;
    logic                     wr_done;
    logic [SIZE_GRP-1:0]      mask_new;

    logic                     rd_oth;
    logic                     rd_start;
    logic                     rd_adv;
    logic                     rd_fin;
    logic                     rd_chain;
    logic                     rd_load;
    logic                     rd_bank;
    logic [ADDR_W-1:0]        rd_addr;
    logic [WORD_W-1:0]        rd_word;

    // Map the sample count to the read address and the reported index.
    function automatic logic [ADDR_W-1:0] rd_order(input logic [ADDR_W-1:0] cnt);
        logic [ADDR_W-1:0] r;
`ifdef FFT_OUT_BITREV_EN
        for (int b = 0; b < ADDR_W; b++) begin
            r[b] = cnt[ADDR_W-1-b];
        end
`else
        r = cnt;
`endif
        return r;
    endfunction

    // Write side: accept only into a bank that is empty or still filling.
    // A completed mask means this group finishes the frame.
    always_comb begin
        grp_rdy_o = (bank_st_q[wr_ptr_q] == B_EMPTY) || (bank_st_q[wr_ptr_q] == B_FILLING);
        wr_en     = grp_val_i && grp_rdy_o;
        mask_new  = mask_q[wr_ptr_q] | (SIZE_GRP'(1) << grp_idx_i);
        wr_done   = wr_en && (mask_new == {SIZE_GRP{1'b1}});
    end

    // Scatter the 8 lanes of an accepted group to k = j*SIZE_GRP + g.
    // A repeated group simply overwrites the same locations.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int j = 0; j < SIZE_GRP; j++) begin
                mem_q[{wr_ptr_q, ADDR_W'(j * SIZE_GRP) + ADDR_W'(grp_idx_i)}]
                    <= grp_dat_i[j*WORD_W +: WORD_W];
            end
        end
    end

    // Read FSM next state: start on a full bank, and leave STREAM after the
    // last handshake unless the other bank is already full (no bubble).
    always_comb begin
        rd_oth   = ~rd_ptr_q;
        rd_start = (rd_st_q == RD_IDLE) && (bank_st_q[rd_ptr_q] == B_FULL);
        rd_adv   = (rd_st_q == RD_STREAM) && rdy_i;
        rd_fin   = rd_adv && (cnt_q == LAST_CNT);
        rd_chain = rd_fin && (bank_st_q[rd_oth] == B_FULL);
        rd_st_d  = rd_st_q;
        case (rd_st_q)
            RD_IDLE:   if (rd_start) rd_st_d = RD_STREAM;
            RD_STREAM: if (rd_fin && !rd_chain) rd_st_d = RD_IDLE;
            default:   rd_st_d = RD_IDLE;
        endcase
    end

    // Read FSM outputs: choose the next sample to register, or hold on stall.
    always_comb begin
        rd_load = 1'b0;
        rd_bank = rd_ptr_q;
        cnt_d   = cnt_q;
        val_d   = val_q;
        last_d  = last_q;
        idx_d   = idx_q;
        re_d    = re_q;
        im_d    = im_q;
        if (rd_start) begin
            rd_load = 1'b1;
            cnt_d   = '0;
        end else if (rd_adv) begin
            if (rd_fin) begin
                if (rd_chain) begin
                    rd_load = 1'b1;
                    rd_bank = rd_oth;
                    cnt_d   = '0;
                end else begin
                    val_d  = 1'b0;
                    last_d = 1'b0;
                end
            end else begin
                rd_load = 1'b1;
                cnt_d   = cnt_q + 1'b1;
            end
        end
        rd_addr = rd_order(cnt_d);
        rd_word = mem_q[{rd_bank, rd_addr}];
        if (rd_load) begin
            val_d  = 1'b1;
            idx_d  = rd_addr;
            last_d = (cnt_d == LAST_CNT);
            re_d   = $signed(rd_word[WORD_W-1:DAT_WD]);
            im_d   = $signed(rd_word[DAT_WD-1:0]);
        end
    end

    // Bank bookkeeping: the writer moves its bank EMPTY -> FILLING -> FULL,
    // the reader moves FULL -> DRAINING -> EMPTY. They never touch the same
    // bank on one edge, because the writer is locked out of FULL/DRAINING banks.
    always_comb begin
        bank_st_d = bank_st_q;
        mask_d    = mask_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        if (wr_en) begin
            if (wr_done) begin
                bank_st_d[wr_ptr_q] = B_FULL;
                mask_d[wr_ptr_q]    = '0;
                wr_ptr_d            = ~wr_ptr_q;
            end else begin
                bank_st_d[wr_ptr_q] = B_FILLING;
                mask_d[wr_ptr_q]    = mask_new;
            end
        end
        if (rd_start) begin
            bank_st_d[rd_ptr_q] = B_DRAINING;
        end
        if (rd_fin) begin
            bank_st_d[rd_ptr_q] = B_EMPTY;
            rd_ptr_d            = rd_oth;
            if (rd_chain) begin
                bank_st_d[rd_oth] = B_DRAINING;
            end
        end
    end

    // Bank state, masks and pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                bank_st_q[i] <= B_EMPTY;
                mask_q[i]    <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            bank_st_q <= bank_st_d;
            mask_q    <= mask_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
        end
    end

    // Read FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_st_q <= RD_IDLE;
        end else begin
            rd_st_q <= rd_st_d;
        end
    end

    // Output sample registers; the previous values persist while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            val_q  <= 1'b0;
            last_q <= 1'b0;
            idx_q  <= '0;
            re_q   <= '0;
            im_q   <= '0;
        end else begin
            cnt_q  <= cnt_d;
            val_q  <= val_d;
            last_q <= last_d;
            idx_q  <= idx_d;
            re_q   <= re_d;
            im_q   <= im_d;
        end
    end

    assign val_o        = val_q;
    assign last_o       = last_q;
    assign idx_o        = idx_q;
    assign fft_dat_re_o = re_q;
    assign fft_dat_im_o = im_q;

endmodule

// File: tb/tb_fft_out_buf.sv
// Bench for fft_out_buf: frame-level reference model (queue of completed
// frames plus a fill buffer) checked every cycle, directed scenarios with
// hand-computed expectations, and a randomized write/backpressure phase.
module tb_fft_out_buf;

    logic               clk;
    logic               rst;
    logic               grp_val;
    logic [2:0]         grp_idx;
    logic [255:0]       grp_dat;
    logic               grp_rdy_o;
    logic               val_o;
    logic               rdy_i;
    logic signed [15:0] fft_dat_re_o;
    logic signed [15:0] fft_dat_im_o;
    logic [5:0]         idx_o;
    logic               last_o;

    int total = 0;
    int bad   = 0;

    fft_out_buf dut (
        .clk          (clk),
        .rst          (rst),
        .grp_val_i    (grp_val),
        .grp_idx_i    (grp_idx),
        .grp_dat_i    (grp_dat),
        .grp_rdy_o    (grp_rdy_o),
        .val_o        (val_o),
        .rdy_i        (rdy_i),
        .fft_dat_re_o (fft_dat_re_o),
        .fft_dat_im_o (fft_dat_im_o),
        .idx_o        (idx_o),
        .last_o       (last_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Order in which samples leave a frame: natural, or 6-bit bit-reversed.
    function automatic int ord(input int n);
        int r;
        r = n;
`ifdef FFT_OUT_BITREV_EN
        r = 0;
        for (int b = 0; b < 6; b++) begin
            if (((n >> b) & 1) != 0) r = r + (32 >> b);
        end
`endif
        return r;
    endfunction

    // ---------------- reference model ----------------
    logic [31:0] fill [64];
    logic [31:0] frm  [2][64];
    int          cedge [2];
    logic [7:0]  mask;
    int          hd, nq, pos, cur, drained, slot, a, e_val, wr_ok;

    initial begin
        hd = 0; nq = 0; pos = 0; cur = 0; drained = 0; mask = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hd = 0; nq = 0; pos = 0; cur = 0; mask = '0;
                chk("rst_val", val_o, 0);
            end else begin
                e_val = (nq > 0 && cedge[hd] < cur) ? 1 : 0;
                chk("m_grp_rdy", grp_rdy_o, (nq < 2) ? 1 : 0);
                chk("m_val", val_o, e_val);
                if (e_val != 0) begin
                    a = ord(pos);
                    chk("m_idx", idx_o, a);
                    chk("m_re", fft_dat_re_o, $signed(frm[hd][a][31:16]));
                    chk("m_im", fft_dat_im_o, $signed(frm[hd][a][15:0]));
                    chk("m_last", last_o, (pos == 63) ? 1 : 0);
                end
                wr_ok = (nq < 2) ? 1 : 0;
                if (e_val != 0 && rdy_i) begin
                    pos++;
                    if (pos == 64) begin
                        pos = 0; hd = hd ^ 1; nq--; drained++;
                    end
                end
                if (grp_val && wr_ok != 0) begin
                    for (int j = 0; j < 8; j++) fill[j*8 + int'(grp_idx)] = grp_dat[j*32 +: 32];
                    mask[grp_idx] = 1'b1;
                    if (mask == 8'hFF) begin
                        slot = (hd + nq) % 2;
                        for (int k = 0; k < 64; k++) frm[slot][k] = fill[k];
                        cedge[slot] = cur + 1;
                        nq++;
                        mask = '0;
                    end
                end
                cur++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [255:0] seq_grp(input int g, input int base, input int isgn);
        logic [255:0] d;
        int k;
        for (int j = 0; j < 8; j++) begin
            k = j*8 + g;
            d[j*32 +: 32] = {16'(base + k), 16'(isgn * k)};
        end
        return d;
    endfunction

    function automatic logic [255:0] rnd_grp();
        logic [255:0] d;
        for (int j = 0; j < 8; j++) d[j*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic wr_grp(input int g, input logic [255:0] d);
        grp_val = 1'b1;
        grp_idx = 3'(g);
        grp_dat = d;
        @(posedge clk); #1;
        grp_val = 1'b0;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        rdy_i = 1'b1;
        grp_val = 1'b0;
        while ((val_o || nq != 0) && c < 400) begin
            @(posedge clk); #1;
            c++;
        end
        chk("idle_reached", (c < 400) ? 1 : 0, 1);
    endtask

    // ---------------- scenarios ----------------
    int found, run, maxrun, seen, chknext, cnt, d0, blocked;
    logic [255:0] dup;

    initial begin
        rst = 1'b1; grp_val = 1'b0; grp_idx = '0; grp_dat = '0; rdy_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_val_o", val_o, 0);
        chk("rst_last_o", last_o, 0);
        chk("rst_idx_o", idx_o, 0);
        chk("rst_re", fft_dat_re_o, 0);
        chk("rst_im", fft_dat_im_o, 0);
        rst = 1'b0;
        #1;
        chk("rst_grp_rdy", grp_rdy_o, 1);

        // Scenario 1: ordered groups, re = k, im = -k.
        for (int g = 0; g < 8; g++) wr_grp(g, seq_grp(g, 0, -1));
        chk("s1_val_at_e0", val_o, 0);
        @(posedge clk); #1;
        chk("s1_val_at_e1", val_o, 1);
        chk("s1_idx0", idx_o, 0);
        chk("s1_re0", fft_dat_re_o, 0);
        chk("s1_im0", fft_dat_im_o, 0);
        @(posedge clk); #1;
`ifdef FFT_OUT_BITREV_EN
        chk("s1_idx1", idx_o, 32);
        chk("s1_re1", fft_dat_re_o, 32);
        chk("s1_im1", fft_dat_im_o, -32);
`else
        chk("s1_idx1", idx_o, 1);
        chk("s1_re1", fft_dat_re_o, 1);
        chk("s1_im1", fft_dat_im_o, -1);
`endif
        found = 0;
        for (int c = 0; c < 80; c++) begin
            if (val_o && last_o) begin found = 1; break; end
            @(posedge clk); #1;
        end
        chk("s1_last_seen", found, 1);
        chk("s1_last_idx", idx_o, 63);
        chk("s1_last_re", fft_dat_re_o, 63);
        @(posedge clk); #1;
        chk("s1_val_after", val_o, 0);
        wait_idle();

        // Scenario 2: out-of-order groups with a duplicate of group 2.
        for (int j = 0; j < 8; j++) dup[j*32 +: 32] = {16'(500 + j), 16'd7};
        wr_grp(5, rnd_grp()); wr_grp(2, rnd_grp()); wr_grp(7, rnd_grp());
        wr_grp(0, rnd_grp()); wr_grp(2, dup);       wr_grp(1, rnd_grp());
        wr_grp(6, rnd_grp()); wr_grp(3, rnd_grp());
        chk("s2_no_early_val", val_o, 0);
        wr_grp(4, rnd_grp());
        found = 0;
        for (int c = 0; c < 100; c++) begin
            if (val_o && idx_o == 6'd2) begin found = 1; break; end
            @(posedge clk); #1;
        end
        chk("s2_idx2_seen", found, 1);
        chk("s2_dup_re", fft_dat_re_o, 500);
        chk("s2_dup_im", fft_dat_im_o, 7);
        wait_idle();

        // Scenario 3: back-to-back frames, second written during first drain.
        run = 0; maxrun = 0; seen = 0; chknext = 0;
        for (int c = 0; c < 160; c++) begin
            if (c < 8) begin
                grp_val = 1'b1; grp_idx = 3'(c); grp_dat = rnd_grp();
            end else if (c < 16) begin
                grp_val = 1'b1; grp_idx = 3'(c - 8); grp_dat = rnd_grp();
            end else begin
                grp_val = 1'b0;
            end
            @(posedge clk); #1;
            if (chknext != 0) begin
                chk("s3_rdy_after_free", grp_rdy_o, 1);
                chknext = 0;
            end
            if (c == 15) chk("s3_rdy_both_full", grp_rdy_o, 0);
            if (val_o) begin
                run++;
                if (run > maxrun) maxrun = run;
            end else begin
                run = 0;
            end
            if (val_o && last_o && seen == 0) begin seen = 1; chknext = 1; end
        end
        grp_val = 1'b0;
        chk("s3_run128", maxrun, 128);
        wait_idle();

        // Scenario 4: random writes (including blocked ones) and random backpressure.
        d0 = drained; blocked = 0;
        for (int c = 0; c < 6000 && drained < d0 + 5; c++) begin
            grp_val = 1'($urandom_range(0, 1));
            grp_idx = 3'($urandom_range(0, 7));
            grp_dat = rnd_grp();
            rdy_i   = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            if (!grp_rdy_o) blocked++;
        end
        grp_val = 1'b0; rdy_i = 1'b1;
        chk("s4_frames_drained", (drained - d0 >= 5) ? 1 : 0, 1);
        chk("s4_saw_blocked", (blocked > 0) ? 1 : 0, 1);
        pulse_reset();

        // Scenario 5: reset mid-stream with a half-written second frame.
        for (int g = 0; g < 8; g++) wr_grp(g, rnd_grp());
        cnt = 0;
        for (int c = 0; c < 200; c++) begin
            if (c < 4) begin
                grp_val = 1'b1; grp_idx = 3'(c); grp_dat = rnd_grp();
            end else begin
                grp_val = 1'b0;
            end
            @(posedge clk); #1;
            if (val_o) cnt++;
            if (cnt == 22) break;
        end
        grp_val = 1'b0;
        chk("s5_reached_k21", cnt, 22);
        rst = 1'b1;
        #1;
        chk("s5_rst_val", val_o, 0);
        chk("s5_rst_last", last_o, 0);
        chk("s5_rst_idx", idx_o, 0);
        chk("s5_rst_re", fft_dat_re_o, 0);
        chk("s5_rst_im", fft_dat_im_o, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("s5_grp_rdy", grp_rdy_o, 1);
        for (int g = 0; g < 8; g++) wr_grp(g, seq_grp(g, 100, 1));
        found = 0;
        for (int c = 0; c < 10; c++) begin
            if (val_o) begin found = 1; break; end
            @(posedge clk); #1;
        end
        chk("s5_restart_seen", found, 1);
        chk("s5_restart_idx", idx_o, 0);
        chk("s5_restart_re", fft_dat_re_o, 100);
        chk("s5_restart_im", fft_dat_im_o, 0);
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
